// File: rtl/upclock.sv
// Count-up timer: counts HH:MM:SS from zero once per prescaled second until it
// reaches a button-set target, then emits a one-cycle out pulse and stops.
module upclock #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned HOUR_MAX = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       EN,
  input  logic       H_SET,
  input  logic       M_SET,
  input  logic       S_SET,
  output logic [3:0] H_h,
  output logic [3:0] H_l,
  output logic [3:0] M_h,
  output logic [3:0] M_l,
  output logic [3:0] S_h,
  output logic [3:0] S_l,
  output logic       out,
  output logic       running
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
  localparam logic [7:0] HourMaxBcd = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  typedef enum logic [1:0] {StSet, StRun, StHold, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   count_q, count_d;
  logic [23:0]   target_q, target_d;
  logic [23:0]   disp_q, disp_d;
  logic          out_q, out_d;
  logic          h_prev_q, m_prev_q, s_prev_q;
  logic          armed_q;

  logic        h_edge, m_edge, s_edge, any_edge;
  logic        tick;
  logic [23:0] count_inc;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // armed_q masks the first cycle after reset so a button held through reset
  // release is not seen as a press.
  assign h_edge   = armed_q & H_SET & ~h_prev_q;
  assign m_edge   = armed_q & M_SET & ~m_prev_q;
  assign s_edge   = armed_q & S_SET & ~s_prev_q;
  assign any_edge = h_edge | m_edge | s_edge;
  assign tick     = (presc_q == TickMax);

  always_comb begin
    count_inc        = count_q;
    count_inc[7:0]   = bcd_inc(count_q[7:0], 8'h59);
    if (count_q[7:0] == 8'h59) begin
      count_inc[15:8] = bcd_inc(count_q[15:8], 8'h59);
      if (count_q[15:8] == 8'h59) begin
        count_inc[23:16] = bcd_inc(count_q[23:16], 8'h99);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StSet;
      presc_q  <= '0;
      count_q  <= '0;
      target_q <= '0;
      disp_q   <= '0;
      out_q    <= 1'b0;
      h_prev_q <= 1'b0;
      m_prev_q <= 1'b0;
      s_prev_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      target_q <= target_d;
      disp_q   <= disp_d;
      out_q    <= out_d;
      h_prev_q <= H_SET;
      m_prev_q <= M_SET;
      s_prev_q <= S_SET;
      armed_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    target_d = target_q;
    out_d    = 1'b0;
    case (state_q)
      StSet: begin
        // A button press in the same cycle as EN wins; the start waits a cycle.
        if (h_edge) begin
          target_d[23:16] = bcd_inc(target_q[23:16], HourMaxBcd);
        end else if (m_edge) begin
          target_d[15:8] = bcd_inc(target_q[15:8], 8'h59);
        end else if (s_edge) begin
          target_d[7:0] = bcd_inc(target_q[7:0], 8'h59);
        end else if (EN) begin
          presc_d = '0;
          count_d = '0;
          if (target_q == 24'h0) begin
            state_d = StDone;
            out_d   = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (tick) begin
          presc_d = '0;
          count_d = count_inc;
          if (count_inc == target_q) begin
            state_d = StDone;
            out_d   = 1'b1;
          end else if (!EN) begin
            state_d = StHold;
          end
        end else if (!EN) begin
          state_d = StHold;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StHold: begin
        if (any_edge) begin
          state_d = StSet;
          count_d = '0;
          presc_d = '0;
        end else if (EN) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (!EN) begin
          state_d = StSet;
          count_d = '0;
        end
      end
      default: state_d = StSet;
    endcase
  end

  always_comb begin
    disp_d  = (state_d == StSet) ? target_d : count_d;
    running = (state_q == StRun);
    out     = out_q;
    {H_h, H_l, M_h, M_l, S_h, S_l} = disp_q;
  end

endmodule

// File: tb/tb_upclock.sv
// Directed bench for upclock with TICK_DIV=4, HOUR_MAX=23.
module tb_upclock;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       EN = 1'b0;
  logic       H_SET = 1'b0;
  logic       M_SET = 1'b0;
  logic       S_SET = 1'b0;
  logic [3:0] H_h, H_l, M_h, M_l, S_h, S_l;
  logic       out;
  logic       running;
  logic [23:0] disp;

  int checks = 0;
  int errors = 0;

  upclock #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
    .clk(clk), .clr(clr), .EN(EN), .H_SET(H_SET), .M_SET(M_SET), .S_SET(S_SET),
    .H_h(H_h), .H_l(H_l), .M_h(M_h), .M_l(M_l), .S_h(S_h), .S_l(S_l),
    .out(out), .running(running)
  );

  assign disp = {H_h, H_l, M_h, M_l, S_h, S_l};

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    EN = 1'b0;
    H_SET = 1'b0;
    M_SET = 1'b0;
    S_SET = 1'b0;
    clr = 1'b0;
    step(2);
    clr = 1'b1;
    step(1);
  endtask

  task automatic press_h(input int n);
    for (int i = 0; i < n; i++) begin
      H_SET = 1'b1; step(1);
      H_SET = 1'b0; step(1);
    end
  endtask

  task automatic press_m(input int n);
    for (int i = 0; i < n; i++) begin
      M_SET = 1'b1; step(1);
      M_SET = 1'b0; step(1);
    end
  endtask

  task automatic press_s(input int n);
    for (int i = 0; i < n; i++) begin
      S_SET = 1'b1; step(1);
      S_SET = 1'b0; step(1);
    end
  endtask

  task automatic test_reset();
    H_SET = 1'b1; M_SET = 1'b1; S_SET = 1'b1; EN = 1'b0;
    clr = 1'b0;
    step(2);
    checks++;
    if ({disp, out, running} !== 26'h0) begin
      $display("FAIL reset_state: got disp=%h out=%b run=%b want 000000 0 0", disp, out, running);
      errors++;
    end
    clr = 1'b1;
    step(3);
    checks++;
    if (disp !== 24'h000000) begin
      $display("FAIL reset_held_buttons: got %h want 000000", disp);
      errors++;
    end
    H_SET = 1'b0; M_SET = 1'b0; S_SET = 1'b0;
    step(1);
    H_SET = 1'b1;
    step(1);
    checks++;
    if (disp !== 24'h010000) begin
      $display("FAIL reset_new_edge: got %h want 010000", disp);
      errors++;
    end
    H_SET = 1'b0;
  endtask

  task automatic test_count3();
    apply_reset();
    press_s(3);
    checks++;
    if (disp !== 24'h000003) begin
      $display("FAIL c3_target: got %h want 000003", disp);
      errors++;
    end
    EN = 1'b1;
    step(1);
    checks++;
    if (running !== 1'b1 || disp !== 24'h0) begin
      $display("FAIL c3_run_entry: got run=%b disp=%h want 1 000000", running, disp);
      errors++;
    end
    step(3);
    checks++;
    if (disp !== 24'h000000) begin
      $display("FAIL c3_cycle3: got %h want 000000", disp);
      errors++;
    end
    step(1);
    checks++;
    if (disp !== 24'h000001) begin
      $display("FAIL c3_cycle4: got %h want 000001", disp);
      errors++;
    end
    step(4);
    checks++;
    if (disp !== 24'h000002) begin
      $display("FAIL c3_cycle8: got %h want 000002", disp);
      errors++;
    end
    step(3);
    checks++;
    if (out !== 1'b0 || disp !== 24'h000002) begin
      $display("FAIL c3_cycle11: got out=%b disp=%h want 0 000002", out, disp);
      errors++;
    end
    step(1);
    checks++;
    if (out !== 1'b1 || disp !== 24'h000003 || running !== 1'b0) begin
      $display("FAIL c3_done: got out=%b disp=%h run=%b want 1 000003 0", out, disp, running);
      errors++;
    end
    step(1);
    checks++;
    if (out !== 1'b0 || disp !== 24'h000003) begin
      $display("FAIL c3_done_hold: got out=%b disp=%h want 0 000003", out, disp);
      errors++;
    end
    EN = 1'b0;
    step(1);
    checks++;
    if (disp !== 24'h000003 || out !== 1'b0) begin
      $display("FAIL c3_back_to_set: got disp=%h out=%b want 000003 0", disp, out);
      errors++;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    press_s(61);
    checks++;
    if (disp !== 24'h000001) begin
      $display("FAIL wrap_sec: got %h want 000001", disp);
      errors++;
    end
    press_h(24);
    checks++;
    if (disp !== 24'h000001) begin
      $display("FAIL wrap_hour: got %h want 000001", disp);
      errors++;
    end
    press_h(5);
    press_m(59);
    checks++;
    if (disp !== 24'h055901) begin
      $display("FAIL wrap_min59: got %h want 055901", disp);
      errors++;
    end
    press_m(1);
    checks++;
    if (disp !== 24'h050001) begin
      $display("FAIL wrap_min00: got %h want 050001", disp);
      errors++;
    end
  endtask

  task automatic test_hold();
    apply_reset();
    press_m(1);
    EN = 1'b1;
    step(1);
    step(6);
    checks++;
    if (disp !== 24'h000001) begin
      $display("FAIL hold_pre: got %h want 000001", disp);
      errors++;
    end
    EN = 1'b0;
    step(1);
    checks++;
    if (running !== 1'b0) begin
      $display("FAIL hold_enter: got run=%b want 0", running);
      errors++;
    end
    step(20);
    checks++;
    if (disp !== 24'h000001 || out !== 1'b0) begin
      $display("FAIL hold_frozen: got disp=%h out=%b want 000001 0", disp, out);
      errors++;
    end
    EN = 1'b1;
    step(1);
    step(1);
    checks++;
    if (disp !== 24'h000001 || running !== 1'b1) begin
      $display("FAIL hold_resume1: got disp=%h run=%b want 000001 1", disp, running);
      errors++;
    end
    step(1);
    checks++;
    if (disp !== 24'h000002) begin
      $display("FAIL hold_resume2: got %h want 000002", disp);
      errors++;
    end
    EN = 1'b0;
  endtask

  task automatic test_carry();
    apply_reset();
    press_h(1);
    EN = 1'b1;
    step(1);
    step(236);
    checks++;
    if (disp !== 24'h000059) begin
      $display("FAIL carry_59s: got %h want 000059", disp);
      errors++;
    end
    step(4);
    checks++;
    if (disp !== 24'h000100) begin
      $display("FAIL carry_1m: got %h want 000100", disp);
      errors++;
    end
    step(14156);
    checks++;
    if (disp !== 24'h005959 || out !== 1'b0) begin
      $display("FAIL carry_5959: got disp=%h out=%b want 005959 0", disp, out);
      errors++;
    end
    step(4);
    checks++;
    if (disp !== 24'h010000 || out !== 1'b1) begin
      $display("FAIL carry_1h: got disp=%h out=%b want 010000 1", disp, out);
      errors++;
    end
    EN = 1'b0;
    step(2);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    press_s(1);
    EN = 1'b1;
    step(1);
    step(3);
    EN = 1'b0;
    step(1);
    checks++;
    if (out !== 1'b1 || disp !== 24'h000001 || running !== 1'b0) begin
      $display("FAIL sim_tick_en_fall: got out=%b disp=%h run=%b want 1 000001 0", out, disp,
               running);
      errors++;
    end
    step(1);
    checks++;
    if (out !== 1'b0) begin
      $display("FAIL sim_pulse_width: got out=%b want 0", out);
      errors++;
    end
    apply_reset();
    H_SET = 1'b1; S_SET = 1'b1;
    step(1);
    checks++;
    if (disp !== 24'h010000) begin
      $display("FAIL sim_h_and_s: got %h want 010000", disp);
      errors++;
    end
    H_SET = 1'b0; S_SET = 1'b0;
    step(1);
  endtask

  task automatic test_zero_target();
    apply_reset();
    EN = 1'b1;
    step(1);
    checks++;
    if (out !== 1'b1 || disp !== 24'h0 || running !== 1'b0) begin
      $display("FAIL zero_done: got out=%b disp=%h run=%b want 1 000000 0", out, disp, running);
      errors++;
    end
    step(1);
    checks++;
    if (out !== 1'b0) begin
      $display("FAIL zero_single_pulse: got out=%b want 0", out);
      errors++;
    end
    EN = 1'b0;
    step(1);
    EN = 1'b1;
    step(1);
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || running !== 1'b0) begin
      $display("FAIL async_reset_pulse: got out=%b run=%b want 0 0", out, running);
      errors++;
    end
    EN = 1'b0;
    step(1);
    clr = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_wrap();
    test_hold();
    test_carry();
    test_simultaneous();
    test_zero_target();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/upclock.md
Name: upclock

Overview:
- Count-up timer; the counterpart to the team's countdown timer.
- User sets a target HH:MM:SS with the H_SET/M_SET/S_SET buttons. While enabled, the block counts up from 00:00:00 once per second, using an internal prescaler on the system clock.
- When the count reaches the target, the block pulses out and stops.
- It drives the same six BCD digit outputs and the same out pulse as the countdown timer, so the display and buzzer logic are shared.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (must be >= 2).
- HOUR_MAX, 99, largest settable hour value; the target hour wraps HOUR_MAX -> 0.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  asynchronous, active-low reset.
- EN  in  1  run level: 1 = count, 0 = stop or hold.
- H_SET  in  1  hour-set button, level input; the block detects the rising edge internally.
- M_SET  in  1  minute-set button, level input; rising edge detected.
- S_SET  in  1  second-set button, level input; rising edge detected.
- H_h, H_l, M_h, M_l, S_h, S_l  out  4 each  displayed BCD digits.
- out  out  1  one-cycle pulse when the count reaches the target.
- running  out  1  high in the RUN state.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=SET; count=00:00:00; target=00:00:00; prescaler=0.
  - out=0, running=0, all digits 0.
  - Edge-detect registers cleared, so a button already held at release does not register an edge.
- Edge detect: a button edge is the current level at 1 with the previous registered level at 0. If several edges arrive in one cycle, only one is applied, with priority H_SET > M_SET > S_SET.
- Display: in SET the digits show the target. In RUN, HOLD and DONE they show the count. Digits are registered.
- State SET:
  - S_SET edge: target seconds +1 in BCD, 59 -> 00, no carry into minutes.
  - M_SET edge: target minutes +1, 59 -> 00, no carry.
  - H_SET edge: target hours +1, HOUR_MAX -> 00.
  - EN=1 and target != 0: go to RUN, clear the prescaler, count stays 00:00:00.
  - EN=1 and target == 0: go directly to DONE and pulse out.
- State RUN:
  - running=1. The prescaler increments every cycle; a tick occurs when prescaler == TICK_DIV-1, and the prescaler then returns to 0.
  - On a tick the count advances in BCD: S_l 9->0 carries to S_h; S_h 5->0 carries to M_l; M_l and M_h carry the same way into hours.
  - The hour digits count up to 99. The count never exceeds the target because the target is at most HOUR_MAX:59:59.
  - If the incremented count equals the target, go to DONE and assert out=1 for exactly that one cycle.
  - EN=0 with no tick in the same cycle: go to HOLD. The prescaler is frozen, not cleared, so the fractional second is preserved.
  - If a tick and EN falling occur in the same cycle, the tick is applied first. Then: DONE if the count matched, otherwise HOLD.
  - Set buttons are ignored.
- State HOLD:
  - Count and prescaler frozen.
  - EN=1: resume RUN; the next tick occurs after the remaining prescaler cycles.
  - Any set-button edge: go to SET, clear count and prescaler; the target is unchanged and is not incremented by that edge.
- State DONE:
  - running=0; count frozen at the target value; out=0 after the first cycle.
  - Set buttons are ignored.
  - EN=0: go to SET, clear the count; the target is retained.
- out:
  - Registered; high for exactly 1 clk cycle per completion.
  - Never asserted in SET or HOLD.
- Reset mid-operation: immediate return to the reset values above from any state, including during the out pulse.

Test Plan (TICK_DIV=4, HOUR_MAX=23):
- Reset while the buttons are held high: after clr is released, no target change until the button goes low then high again. All digits 0, out=0.
- Set the target to 00:00:03 with 3 S_SET edges, then raise EN:
  - Count 00:00:01, 00:00:02, 00:00:03 on cycles 4, 8 and 12 after RUN entry.
  - out high only on the cycle the count becomes 03; DONE holds 00:00:03.
  - EN low returns to SET showing 00:00:03.
- Wrap rules: 61 S_SET edges give target seconds 01. 24 H_SET edges give target hours 00. M_SET from 59 gives 00 with hours unchanged.
- Hold and resume: target 00:01:00, EN high for 6 cycles (count 00:00:01, prescaler 2), EN low for 20 cycles with the count frozen, then EN high again. The next tick arrives 2 cycles later and the count reaches 00:00:02.
- Carry chain: target 01:00:00. Verify the transitions 00:00:59 -> 00:01:00 and 00:59:59 -> 01:00:00, with out on the final tick.
- Simultaneous events and edge cases:
  - A tick with EN falling on the same cycle as the final count: the block enters DONE and out pulses.
  - H_SET and S_SET edges in the same cycle: only the hours increment.
  - EN=1 with target 00:00:00: DONE immediately, with a single out pulse.
